// File: rtl/branch_resolver.sv
// RV64I branch/jump resolver: two-stage valid/ready pipeline producing taken, target
// and link results, with saturating resolved/taken/mispredict statistics.
module branch_resolver #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link,
  output logic             mispredict,
  output logic             misaligned,
  output logic             illegal,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_mispred
);

  logic            s1_valid;
  logic [2:0]      s1_funct3;
  logic            s1_is_jal;
  logic            s1_is_jalr;
  logic            s1_pred_taken;
  logic [XLEN-1:0] s1_pc;
  logic [XLEN-1:0] s1_rs1;
  logic [XLEN-1:0] s1_rs2;
  logic [XLEN-1:0] s1_imm;

  logic            s2_advance;
  logic            out_fire;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            cond;
  logic            nxt_taken;
  logic            nxt_illegal;
  logic [XLEN-1:0] nxt_target;
  logic [XLEN-1:0] nxt_link;
  logic [XLEN-1:0] jalr_sum;

  // The output register can take a new result when it is empty or being drained.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;
  assign out_fire   = out_valid && out_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic inc);
    return (inc && (value != '1)) ? value + CNT_W'(1) : value;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    eq          = (s1_rs1 == s1_rs2);
    lt          = ($signed(s1_rs1) < $signed(s1_rs2));
    ltu         = (s1_rs1 < s1_rs2);
    cond        = 1'b0;
    nxt_illegal = 1'b0;
    case (s1_funct3)
      3'd0:    cond = eq;
      3'd1:    cond = !eq;
      3'd4:    cond = lt;
      3'd5:    cond = !lt;
      3'd6:    cond = ltu;
      3'd7:    cond = !ltu;
      default: nxt_illegal = 1'b1;
    endcase

    jalr_sum = s1_rs1 + s1_imm;
    nxt_link = s1_pc + XLEN'(4);
    if (s1_is_jalr) begin
      nxt_taken   = 1'b1;
      nxt_illegal = 1'b0;
      nxt_target  = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (s1_is_jal) begin
      nxt_taken   = 1'b1;
      nxt_illegal = 1'b0;
      nxt_target  = s1_pc + s1_imm;
    end else begin
      nxt_taken   = cond;
      nxt_target  = cond ? (s1_pc + s1_imm) : nxt_link;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_funct3     <= '0;
      s1_is_jal     <= 1'b0;
      s1_is_jalr    <= 1'b0;
      s1_pred_taken <= 1'b0;
      s1_pc         <= '0;
      s1_rs1        <= '0;
      s1_rs2        <= '0;
      s1_imm        <= '0;
      out_valid     <= 1'b0;
      taken         <= 1'b0;
      target        <= '0;
      link          <= '0;
      mispredict    <= 1'b0;
      misaligned    <= 1'b0;
      illegal       <= 1'b0;
      cnt_branch    <= '0;
      cnt_taken     <= '0;
      cnt_mispred   <= '0;
    end else begin
      if (out_fire) begin
        cnt_branch  <= sat_inc(cnt_branch, 1'b1);
        cnt_taken   <= sat_inc(cnt_taken, taken);
        cnt_mispred <= sat_inc(cnt_mispred, mispredict);
      end

      if (s2_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          taken      <= nxt_taken;
          target     <= nxt_target;
          link       <= nxt_link;
          mispredict <= nxt_taken ^ s1_pred_taken;
          misaligned <= nxt_taken && (nxt_target[1:0] != 2'b00);
          illegal    <= nxt_illegal;
        end
      end

      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_funct3     <= funct3;
          s1_is_jal     <= is_jal;
          s1_is_jalr    <= is_jalr;
          s1_pred_taken <= pred_taken;
          s1_pc         <= pc;
          s1_rs1        <= rs1;
          s1_rs2        <= rs2;
          s1_imm        <= imm;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed cases plus randomized traffic
// scored against a queue-based behavioural model; a CNT_W=3 copy exercises saturation.
module tb_branch_resolver;

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic        mispredict;
    logic        misaligned;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        is_jal;
  logic        is_jalr;
  logic        pred_taken;
  logic [63:0] pc;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [63:0] target;
  logic [63:0] link;
  logic        mispredict;
  logic        misaligned;
  logic        illegal;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_taken;
  logic [31:0] cnt_mispred;

  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_taken;
  logic [63:0] s_target;
  logic [63:0] s_link;
  logic        s_mispredict;
  logic        s_misaligned;
  logic        s_illegal;
  logic [2:0]  s_cnt_branch;
  logic [2:0]  s_cnt_taken;
  logic [2:0]  s_cnt_mispred;

  int n_total = 0;
  int n_pass  = 0;

  exp_t        q[$];
  logic [31:0] m_branch;
  logic [31:0] m_taken;
  logic [31:0] m_mispred;
  logic        chk_en = 1'b0;
  logic        held   = 1'b0;
  exp_t        prev;

  branch_resolver #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .is_jal(is_jal), .is_jalr(is_jalr), .pred_taken(pred_taken),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .link(link), .mispredict(mispredict), .misaligned(misaligned), .illegal(illegal),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_mispred(cnt_mispred)
  );

  branch_resolver #(.XLEN(64), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .funct3(funct3), .is_jal(is_jal), .is_jalr(is_jalr), .pred_taken(pred_taken),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(s_out_valid), .out_ready(out_ready), .taken(s_taken), .target(s_target),
    .link(s_link), .mispredict(s_mispredict), .misaligned(s_misaligned), .illegal(s_illegal),
    .cnt_branch(s_cnt_branch), .cnt_taken(s_cnt_taken), .cnt_mispred(s_cnt_mispred)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference result computed straight from the RV64I branch rules.
  function automatic exp_t ref_result(input logic [2:0] f3, input logic jal, input logic jalr,
                                      input logic pred, input logic [63:0] a_pc,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] im);
    exp_t r;
    logic signed_lt;
    logic c;
    signed_lt = (a[63] != b[63]) ? a[63] : (a < b);
    r = '0;
    c = 1'b0;
    case (f3)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = signed_lt;
      3'd5: c = !signed_lt;
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: r.illegal = 1'b1;
    endcase
    r.link = a_pc + 64'd4;
    if (jalr) begin
      r.taken = 1'b1; r.illegal = 1'b0; r.target = (a + im) & ~64'd1;
    end else if (jal) begin
      r.taken = 1'b1; r.illegal = 1'b0; r.target = a_pc + im;
    end else begin
      r.taken = c; r.target = c ? a_pc + im : a_pc + 64'd4;
    end
    r.mispredict = (r.taken != pred);
    r.misaligned = r.taken && (r.target[1:0] != 2'b00);
    return r;
  endfunction

  // Scoreboard: compares every result handshake, counters and stall stability.
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    if (chk_en) begin
      cur = '{taken, target, link, mispredict, misaligned, illegal};
      check("cnt_branch", 64'(cnt_branch), 64'(m_branch));
      check("cnt_taken", 64'(cnt_taken), 64'(m_taken));
      check("cnt_mispred", 64'(cnt_mispred), 64'(m_mispred));
      if (held && !reset) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_target", cur.target, prev.target);
        check("hold_link", cur.link, prev.link);
        check("hold_flags", 64'({cur.taken, cur.mispredict, cur.misaligned, cur.illegal}),
              64'({prev.taken, prev.mispredict, prev.misaligned, prev.illegal}));
      end
      if (reset) begin
        q.delete();
        m_branch = '0; m_taken = '0; m_mispred = '0;
        held = 1'b0;
      end else begin
        if (out_valid) check("no_stale_result", 64'(q.size() > 0), 64'd1);
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          check("sb_taken", 64'(taken), 64'(e.taken));
          check("sb_target", target, e.target);
          check("sb_link", link, e.link);
          check("sb_mispredict", 64'(mispredict), 64'(e.mispredict));
          check("sb_misaligned", 64'(misaligned), 64'(e.misaligned));
          check("sb_illegal", 64'(illegal), 64'(e.illegal));
          if (m_branch != '1) m_branch++;
          if (e.taken && m_taken != '1) m_taken++;
          if (e.mispredict && m_mispred != '1) m_mispred++;
        end
        held = out_valid && !out_ready;
        prev = cur;
        if (in_valid && in_ready)
          q.push_back(ref_result(funct3, is_jal, is_jalr, pred_taken, pc, rs1, rs2, imm));
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic j, input logic jr, input logic p,
                       input logic [63:0] a_pc, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] im);
    funct3 = f; is_jal = j; is_jalr = jr; pred_taken = p;
    pc = a_pc; rs1 = a; rs2 = b; imm = im;
  endtask

  task automatic one_shot(input string name, input logic [2:0] f, input logic j, input logic jr,
                          input logic p, input logic [63:0] a_pc, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] im, input logic exp_taken,
                          input logic [63:0] exp_target, input logic exp_mis,
                          input logic exp_ill);
    bit got;
    @(posedge clk); #1;
    drive(f, j, jr, p, a_pc, a, b, im);
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    check({name, "_arrived"}, 64'(got), 64'd1);
    if (got) begin
      check({name, "_taken"}, 64'(taken), 64'(exp_taken));
      check({name, "_target"}, target, exp_target);
      check({name, "_link"}, link, a_pc + 64'd4);
      check({name, "_misaligned"}, 64'(misaligned), 64'(exp_mis));
      check({name, "_illegal"}, 64'(illegal), 64'(exp_ill));
    end
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7fff_ffff_ffff_ffff;
      3:       return '1;
      4:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_fields();
    logic [63:0] a;
    a = rand_op();
    drive(3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          1'($urandom_range(0, 1)), {$urandom, $urandom} & ~64'd3 | 64'($urandom_range(0, 1) * 2),
          a, ($urandom_range(0, 3) == 0) ? a : rand_op(),
          ($urandom_range(0, 1) == 0) ? 64'($signed(12'($urandom))) : {$urandom, $urandom});
  endtask

  initial begin
    bit pend;
    bit stale_seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    m_branch = '0; m_taken = '0; m_mispred = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_target", target, 64'd0);
    check("rst_cnt_branch", 64'(cnt_branch), 64'd0);
    chk_en = 1'b1;

    // BEQ taken against a not-taken prediction, with the exact two-cycle latency.
    @(posedge clk); #1;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 64'h1000, 64'h5, 64'h5, 64'h40);
    in_valid = 1'b1;
    @(negedge clk);
    check("beq_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("beq_lat1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("beq_lat2_valid", 64'(out_valid), 64'd1);
    check("beq_taken", 64'(taken), 64'd1);
    check("beq_target", target, 64'h1040);
    check("beq_link", link, 64'h1004);
    check("beq_mispredict", 64'(mispredict), 64'd1);
    @(negedge clk);
    check("beq_cnt_mispred", 64'(cnt_mispred), 64'd1);
    check("beq_drained", 64'(out_valid), 64'd0);

    one_shot("blt_ovf", 3'd4, 1'b0, 1'b0, 1'b1, 64'h3000, 64'h8000_0000_0000_0000, 64'h1,
             64'h10, 1'b1, 64'h3010, 1'b0, 1'b0);
    one_shot("bltu", 3'd6, 1'b0, 1'b0, 1'b0, 64'h3000, 64'h8000_0000_0000_0000, 64'h1,
             64'h10, 1'b0, 64'h3004, 1'b0, 1'b0);
    one_shot("jalr", 3'd0, 1'b0, 1'b1, 1'b1, 64'h5000, 64'h2003, 64'h0, 64'h4,
             1'b1, 64'h2006, 1'b1, 1'b0);
    one_shot("f3_2", 3'd2, 1'b0, 1'b0, 1'b0, 64'h6000, 64'h7, 64'h7, 64'h20,
             1'b0, 64'h6004, 1'b0, 1'b1);
    one_shot("jal_jalr", 3'd3, 1'b1, 1'b1, 1'b1, 64'h7000, 64'h100, 64'h0, 64'h8,
             1'b1, 64'h108, 1'b0, 1'b0);
    one_shot("jal_wrap", 3'd0, 1'b1, 1'b0, 1'b1, 64'hffff_ffff_ffff_fffc, 64'h0, 64'h1,
             64'h8, 1'b1, 64'h4, 1'b0, 1'b0);

    // Four back-to-back requests with the output stalled for three cycles.
    @(posedge clk); #1;
    drive(3'd1, 1'b0, 1'b0, 1'b1, 64'h100, 64'h1, 64'h2, 64'h20);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_acc_a", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(3'd5, 1'b0, 1'b0, 1'b1, 64'h104, '1, 64'h0, 64'h40);
    @(negedge clk);
    check("bp_acc_b", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(3'd7, 1'b0, 1'b0, 1'b0, 64'h108, '1, 64'h0, 64'hffff_ffff_ffff_fff8);
    @(negedge clk);
    check("bp_first_valid", 64'(out_valid), 64'd1);
    check("bp_first_target", target, 64'h120);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_stall_target", target, 64'h120);
    check("bp_stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(3'd0, 1'b1, 1'b0, 1'b1, 64'h10c, 64'h0, 64'h0, 64'h100);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_all_emerged", 64'(q.size()), 64'd0);

    // Reset with both stages full discards everything.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 64'h200, 64'h1, 64'h1, 64'h8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(3'd1, 1'b0, 1'b0, 1'b0, 64'h204, 64'h1, 64'h1, 64'h8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_full_in_ready", 64'(in_ready), 64'd0);
    check("rst_full_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_cnt_branch", 64'(cnt_branch), 64'd0);
    check("rst_mid_cnt_taken", 64'(cnt_taken), 64'd0);
    stale_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale_seen = 1'b1;
    end
    check("rst_no_stale", 64'(stale_seen), 64'd0);

    // Saturation on the 3-bit counter copy: 7 taken, then 10 more.
    for (int batch = 0; batch < 2; batch++) begin
      for (int i = 0; i < (batch == 0 ? 7 : 10); i++) begin
        @(posedge clk); #1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 64'h400 + 64'(i * 4), 64'h9, 64'h9, 64'h10);
        in_valid = 1'b1;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sat_cnt_taken", 64'(s_cnt_taken), 64'd7);
      check("sat_cnt_branch", 64'(s_cnt_branch), 64'd7);
      check("sat_cnt_mispred", 64'(s_cnt_mispred), 64'd7);
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pend = in_valid && !in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_fields();
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("final_drain", 64'(q.size()), 64'd0);
    check("final_out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
